// File: rtl/sd_img_pkg.sv
// Shared types and helpers for the SD image byte-to-pixel path.
// Provides the frame FSM state encoding and the byte-counter width helper.
package sd_img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int MAX_BPP = 4;

  function automatic int bcnt_w(input int bpp);
    return (bpp > 1) ? $clog2(bpp) : 1;
  endfunction

endpackage

// File: rtl/sd_byte_packer.sv
// Assembles BPP consecutive bytes into one pixel word.
// pix_word/pix_done are valid in the same cycle as the final byte.
module sd_byte_packer
  import sd_img_pkg::*;
#(
  parameter int BPP        = 2,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic [8*BPP-1:0] pix_word,
  output logic             pix_done
);

  localparam int BC_W = bcnt_w(BPP);
  localparam logic [BC_W-1:0] LAST = BC_W'(BPP - 1);

  logic [BC_W-1:0]  cnt_q, cnt_d, cnt_eff_s, lane_s;
  logic [8*BPP-1:0] word_q, word_d, word_s;

  // A clear coinciding with a byte makes that byte lane 0 of a fresh pixel.
  always_comb begin
    cnt_eff_s = clr ? '0 : cnt_q;
    word_s    = clr ? '0 : word_q;
    lane_s    = BIG_ENDIAN ? (LAST - cnt_eff_s) : cnt_eff_s;
    for (int i = 0; i < BPP; i++) begin
      if (in_valid && (lane_s == BC_W'(i))) begin
        word_s[8*i +: 8] = in_byte;
      end
    end
    pix_done = in_valid && (cnt_eff_s == LAST);
    cnt_d    = cnt_eff_s;
    if (in_valid) begin
      cnt_d = pix_done ? '0 : (cnt_eff_s + BC_W'(1));
    end
    word_d   = word_s;
    pix_word = word_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/sd_pixel_window.sv
// Packs SD-card bytes into pixels, tracks source frame position and
// forwards only pixels inside a runtime-offset, edge-clamped crop window.
module sd_pixel_window
  import sd_img_pkg::*;
#(
  parameter int BPP        = 2,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int IMG_W      = 1936,
  parameter int IMG_H      = 1088,
  parameter int CROP_W     = 1024,
  parameter int CROP_H     = 768,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [CNT_W-1:0] x_off,
  input  logic [CNT_W-1:0] y_off,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic [8*BPP-1:0] pix_data,
  output logic             pix_valid,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W:0]   IMG_W_L  = (CNT_W+1)'(IMG_W);
  localparam logic [CNT_W:0]   IMG_H_L  = (CNT_W+1)'(IMG_H);
  localparam logic [CNT_W:0]   CROP_W_L = (CNT_W+1)'(CROP_W);
  localparam logic [CNT_W:0]   CROP_H_L = (CNT_W+1)'(CROP_H);
  localparam logic [CNT_W:0]   ONE_L    = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(IMG_H - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, xoff_q, xoff_d, yoff_q, yoff_d;
  logic [8*BPP-1:0] pix_data_q, pix_data_d;
  logic             pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic             frame_done_q, frame_done_d, busy_q, busy_d, overrun_q, overrun_d;

  logic             byte_accept_s, pix_done_s, in_win_s, last_x_s, last_y_s, frame_last_s;
  logic [8*BPP-1:0] pix_word_s;
  logic [CNT_W-1:0] h_eff_s, v_eff_s, xoff_eff_s, yoff_eff_s;
  logic [CNT_W:0]   x_sum_s, y_sum_s, x_end_s, y_end_s;

  assign byte_accept_s = in_valid && (frame_start || (state_q == ST_ACTIVE));

  sd_byte_packer #(
    .BPP        (BPP),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (frame_start),
    .in_valid (byte_accept_s),
    .in_byte  (in_byte),
    .pix_word (pix_word_s),
    .pix_done (pix_done_s)
  );

  // frame_start takes effect combinationally so a coincident byte belongs to the new frame.
  always_comb begin
    h_eff_s    = frame_start ? '0    : h_q;
    v_eff_s    = frame_start ? '0    : v_q;
    xoff_eff_s = frame_start ? x_off : xoff_q;
    yoff_eff_s = frame_start ? y_off : yoff_q;

    x_sum_s = {1'b0, xoff_eff_s} + CROP_W_L;
    y_sum_s = {1'b0, yoff_eff_s} + CROP_H_L;
    x_end_s = (x_sum_s > IMG_W_L) ? IMG_W_L : x_sum_s;
    y_end_s = (y_sum_s > IMG_H_L) ? IMG_H_L : y_sum_s;

    in_win_s = (h_eff_s >= xoff_eff_s) && ({1'b0, h_eff_s} < x_end_s) &&
               (v_eff_s >= yoff_eff_s) && ({1'b0, v_eff_s} < y_end_s);
    last_x_s     = (({1'b0, h_eff_s} + ONE_L) == x_end_s);
    last_y_s     = (({1'b0, v_eff_s} + ONE_L) == y_end_s);
    frame_last_s = (h_eff_s == H_LAST) && (v_eff_s == V_LAST);
  end

  always_comb begin
    state_d      = state_q;
    h_d          = h_eff_s;
    v_d          = v_eff_s;
    xoff_d       = xoff_eff_s;
    yoff_d       = yoff_eff_s;
    pix_data_d   = pix_data_q;
    pix_valid_d  = 1'b0;
    sof_d        = 1'b0;
    eol_d        = 1'b0;
    eof_d        = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = frame_start ? 1'b0 : overrun_q;

    if (frame_start) begin
      state_d = ST_ACTIVE;
    end else if ((state_q == ST_DONE) && in_valid) begin
      overrun_d = 1'b1;
    end

    if (pix_done_s) begin
      if (h_eff_s == H_LAST) begin
        h_d = '0;
        v_d = (v_eff_s == V_LAST) ? '0 : (v_eff_s + CNT_W'(1));
      end else begin
        h_d = h_eff_s + CNT_W'(1);
      end
      if (in_win_s) begin
        pix_valid_d = 1'b1;
        pix_data_d  = pix_word_s;
        sof_d       = (h_eff_s == xoff_eff_s) && (v_eff_s == yoff_eff_s);
        eol_d       = last_x_s;
        eof_d       = last_x_s && last_y_s;
      end
      if (frame_last_s) begin
        state_d      = ST_DONE;
        frame_done_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      xoff_q       <= '0;
      yoff_q       <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      xoff_q       <= xoff_d;
      yoff_q       <= yoff_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_sof    = sof_q;
  assign pix_eol    = eol_q;
  assign pix_eof    = eof_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
